// File: rtl/max_pool_2d.sv
// Streaming 2x2 stride-2 pooler with a half-row line buffer, runtime row width and bypass.
// Define POOL_AVG_EN to add a sof-latched pool_mode input selecting average pooling.
module max_pool_2d #(
  parameter int unsigned DWIDTH   = 20,
  parameter int unsigned MAX_COLS = 64,
  parameter int unsigned COL_W    = $clog2(MAX_COLS) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en_pool,
`ifdef POOL_AVG_EN
  input  logic              pool_mode,
`endif
  input  logic [COL_W-1:0]  cols,
  input  logic              sof_in,
  input  logic [DWIDTH-1:0] data_in,
  input  logic              valid_in,
  output logic [DWIDTH-1:0] data_out,
  output logic              valid_out,
  output logic              eol_out
);

`ifdef POOL_AVG_EN
  localparam int unsigned LW = DWIDTH + 1;
`else
  localparam int unsigned LW = DWIDTH;
`endif
  localparam int unsigned Depth = MAX_COLS / 2;
  localparam int unsigned AW    = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [COL_W-1:0] One     = COL_W'(1);
  localparam logic [COL_W-1:0] MaxCols = COL_W'(MAX_COLS);

  logic [COL_W-1:0]  col_q, col_d;
  logic              row_odd_q, row_odd_d;
  logic [DWIDTH-1:0] h_r_q, h_r_d;
  logic              en_q, en_d;
  logic [COL_W-1:0]  cols_q, cols_d;
  logic [DWIDTH-1:0] data_out_q, data_out_d;
  logic              valid_out_q, valid_out_d;
  logic              eol_out_q, eol_out_d;
  logic [LW-1:0]     linebuf_q [Depth];

  logic              start;
  logic              en_eff;
  logic [COL_W-1:0]  cols_eff;
  logic [COL_W-1:0]  col_cur;
  logic              row_cur;
  logic              col_last;
  logic [AW-1:0]     lb_idx;
  logic [LW-1:0]     lb_rd;
  logic              lb_we;
  logic [DWIDTH-1:0] hmax;
  logic [LW-1:0]     hval;
  logic [DWIDTH-1:0] pool_max;
  logic [DWIDTH-1:0] pooled;

  // A sof pixel is processed with the newly presented configuration as (row 0, col 0).
  assign start    = valid_in & sof_in;
  assign en_eff   = start ? en_pool : en_q;
  assign cols_eff = start ? (cols & ~One) : cols_q;
  assign col_cur  = start ? '0 : col_q;
  assign row_cur  = start ? 1'b0 : row_odd_q;
  // Wrapping at MAX_COLS-1 too keeps the line buffer index in range for oversized widths.
  assign col_last = (col_cur == cols_eff - One) || (col_cur == MaxCols - One);
  assign lb_idx   = col_cur[AW:1];
  assign lb_rd    = linebuf_q[lb_idx];

  assign hmax     = (h_r_q > data_in) ? h_r_q : data_in;
  assign pool_max = (lb_rd[DWIDTH-1:0] > hmax) ? lb_rd[DWIDTH-1:0] : hmax;

`ifdef POOL_AVG_EN
  logic              mode_q, mode_d;
  logic              mode_eff;
  logic [DWIDTH+1:0] sum4;

  assign mode_eff = start ? pool_mode : mode_q;
  assign hval     = mode_eff ? ({1'b0, h_r_q} + {1'b0, data_in}) : {1'b0, hmax};
  assign sum4     = {1'b0, lb_rd} + {1'b0, hval};
  assign pooled   = mode_eff ? sum4[DWIDTH+1:2] : pool_max;

  always_comb begin
    mode_d = mode_q;
    if (start) mode_d = pool_mode;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) mode_q <= 1'b0;
    else        mode_q <= mode_d;
  end
`else
  assign hval   = hmax;
  assign pooled = pool_max;
`endif

  always_comb begin
    col_d       = col_q;
    row_odd_d   = row_odd_q;
    h_r_d       = h_r_q;
    en_d        = en_q;
    cols_d      = cols_q;
    data_out_d  = data_out_q;
    valid_out_d = 1'b0;
    eol_out_d   = 1'b0;
    lb_we       = 1'b0;
    if (start) begin
      en_d   = en_pool;
      cols_d = cols & ~One;
    end
    if (valid_in) begin
      if (!en_eff) begin
        data_out_d  = data_in;
        valid_out_d = 1'b1;
        col_d       = '0;
        row_odd_d   = 1'b0;
      end else begin
        if (!col_cur[0]) begin
          h_r_d = data_in;
        end else if (!row_cur) begin
          lb_we = 1'b1;
        end else begin
          data_out_d  = pooled;
          valid_out_d = 1'b1;
          eol_out_d   = col_last;
        end
        if (col_last) begin
          col_d     = '0;
          row_odd_d = ~row_cur;
        end else begin
          col_d     = col_cur + One;
          row_odd_d = row_cur;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q       <= '0;
      row_odd_q   <= 1'b0;
      h_r_q       <= '0;
      en_q        <= 1'b1;
      cols_q      <= MaxCols;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      eol_out_q   <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_odd_q   <= row_odd_d;
      h_r_q       <= h_r_d;
      en_q        <= en_d;
      cols_q      <= cols_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      eol_out_q   <= eol_out_d;
    end
  end

  // Line buffer is always written on an even row before the odd row reads it.
  always_ff @(posedge clk) begin
    if (lb_we) linebuf_q[lb_idx] <= hval;
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign eol_out   = eol_out_q;

endmodule

// File: tb/tb_max_pool_2d.sv
// Self-checking bench for max_pool_2d: directed test-plan scenarios plus randomized frames
// checked against a frame-array window model.
module tb_max_pool_2d;
  localparam int unsigned DW = 20;
  localparam int unsigned MC = 64;
  localparam int unsigned CW = $clog2(MC) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en_pool;
  logic          pool_mode;
  logic [CW-1:0] cols;
  logic          sof_in;
  logic [DW-1:0] data_in;
  logic          valid_in;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          eol_out;

  int checks = 0;
  int errors = 0;

  // Reference model state: current frame pixels in arrival order.
  logic          m_en;
  logic          m_avg;
  int            m_w;
  logic [DW-1:0] m_px[$];
  logic          exp_v;
  logic          exp_eol;
  logic [DW-1:0] exp_d;

  max_pool_2d #(.DWIDTH(DW), .MAX_COLS(MC), .COL_W(CW)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .en_pool   (en_pool),
`ifdef POOL_AVG_EN
    .pool_mode (pool_mode),
`endif
    .cols      (cols),
    .sof_in    (sof_in),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .eol_out   (eol_out)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_en  = 1'b1;
    m_avg = 1'b0;
    m_w   = MC;
    m_px.delete();
  endtask

  // Drives one cycle at the negedge, predicts the output, and returns at posedge+1.
  task automatic drive(input logic v, input logic s, input logic [DW-1:0] d);
    int n, r, c, w;
    longint unsigned a0, a1, b0, b1, mx;
    @(negedge clk);
    valid_in = v;
    sof_in   = s;
    data_in  = d;
    exp_v    = 1'b0;
    exp_eol  = 1'b0;
    exp_d    = '0;
    if (v) begin
      if (s) begin
        m_en  = en_pool;
        m_avg = pool_mode;
        m_w   = int'(cols) & ~1;
        m_px.delete();
      end
      if (!m_en) begin
        exp_v = 1'b1;
        exp_d = d;
      end else begin
        m_px.push_back(d);
        w = m_w;
        n = m_px.size() - 1;
        r = n / w;
        c = n % w;
        if ((r % 2 == 1) && (c % 2 == 1)) begin
          a0 = m_px[(r-1)*w + c-1];
          a1 = m_px[(r-1)*w + c];
          b0 = m_px[r*w + c-1];
          b1 = m_px[r*w + c];
          if (m_avg) begin
            exp_d = DW'((a0 + a1 + b0 + b1) >> 2);
          end else begin
            mx = a0;
            if (a1 > mx) mx = a1;
            if (b0 > mx) mx = b0;
            if (b1 > mx) mx = b1;
            exp_d = DW'(mx);
          end
          exp_v   = 1'b1;
          exp_eol = (c == w - 1);
        end
      end
    end
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    sof_in   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (data_out !== '0 || valid_out !== 1'b0 || eol_out !== 1'b0) begin
      errors++;
      $display("FAIL reset: got d=%0d v=%b eol=%b want 0 0 0", data_out, valid_out, eol_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    drive(1'b0, 1'b0, '0);
    checks++;
    if (valid_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got v=%b want 0", valid_out);
    end
  endtask

  task automatic test_basic(input int gap, input string name);
    logic [DW-1:0] px [8] = '{1, 5, 2, 3, 4, 0, 9, 7};
    int nout = 0;
    cols    = CW'(4);
    en_pool = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, i == 0, px[i]);
      checks++;
      if (valid_out !== exp_v || (exp_v && (data_out !== exp_d || eol_out !== exp_eol))) begin
        errors++;
        $display("FAIL %s px%0d: got v=%b d=%0d eol=%b want v=%b d=%0d eol=%b", name, i,
                 valid_out, data_out, eol_out, exp_v, exp_d, exp_eol);
      end
      if (valid_out === 1'b1) nout++;
      for (int g = 0; g < gap; g++) begin
        drive(1'b0, 1'b0, DW'($urandom));
        checks++;
        if (valid_out !== 1'b0) begin
          errors++;
          $display("FAIL %s bubble: got v=%b want 0", name, valid_out);
        end
      end
    end
    checks++;
    if (nout != 2) begin
      errors++;
      $display("FAIL %s count: got %0d outputs want 2", name, nout);
    end
  endtask

  task automatic test_bypass();
    logic [DW-1:0] px [3] = '{10, 20, 30};
    en_pool = 1'b0;
    cols    = CW'(4);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, i == 0, px[i]);
      checks++;
      if (valid_out !== 1'b1 || data_out !== px[i] || eol_out !== 1'b0) begin
        errors++;
        $display("FAIL bypass px%0d: got v=%b d=%0d eol=%b want 1 %0d 0", i, valid_out,
                 data_out, eol_out, px[i]);
      end
      drive(1'b0, 1'b0, '0);
      checks++;
      if (valid_out !== 1'b0) begin
        errors++;
        $display("FAIL bypass_gap: got v=%b want 0", valid_out);
      end
    end
    en_pool = 1'b1;
  endtask

  task automatic test_mid_sof();
    logic [DW-1:0] px [6] = '{1, 5, 2, 3, 4, 0};
    int nout = 0;
    cols    = CW'(4);
    en_pool = 1'b1;
    for (int i = 0; i < 6; i++) drive(1'b1, i == 0, px[i]);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, i == 0, DW'(8));
      checks++;
      if (valid_out !== exp_v || (exp_v && (data_out !== 8 || eol_out !== exp_eol))) begin
        errors++;
        $display("FAIL mid_sof px%0d: got v=%b d=%0d eol=%b want v=%b d=8 eol=%b", i,
                 valid_out, data_out, eol_out, exp_v, exp_eol);
      end
      if (valid_out === 1'b1) nout++;
    end
    checks++;
    if (nout != 2) begin
      errors++;
      $display("FAIL mid_sof count: got %0d outputs want 2", nout);
    end
  endtask

  task automatic test_async_reset();
    logic [DW-1:0] px [6] = '{1, 5, 2, 3, 4, 0};
    logic [DW-1:0] fr [4] = '{3, 1, 2, 6};
    cols    = CW'(4);
    en_pool = 1'b1;
    for (int i = 0; i < 6; i++) drive(1'b1, i == 0, px[i]);
    checks++;
    if (valid_out !== 1'b1 || data_out !== 5) begin
      errors++;
      $display("FAIL areset_pre: got v=%b d=%0d want 1 5", valid_out, data_out);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (data_out !== '0 || valid_out !== 1'b0 || eol_out !== 1'b0) begin
      errors++;
      $display("FAIL areset_now: got d=%0d v=%b eol=%b want 0 0 0", data_out, valid_out,
               eol_out);
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, DW'($urandom));
      checks++;
      if (valid_out !== 1'b0) begin
        errors++;
        $display("FAIL areset_nosof px%0d: got v=%b want 0", i, valid_out);
      end
    end
    cols = CW'(2);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, i == 0, fr[i]);
      checks++;
      if (valid_out !== exp_v || (exp_v && (data_out !== exp_d || eol_out !== exp_eol))) begin
        errors++;
        $display("FAIL areset_new px%0d: got v=%b d=%0d eol=%b want v=%b d=%0d eol=%b", i,
                 valid_out, data_out, eol_out, exp_v, exp_d, exp_eol);
      end
    end
  endtask

  task automatic test_random();
    int c, rows;
    for (int f = 0; f < 14; f++) begin
      c       = (f == 5) ? MC : $urandom_range(2, 17);
      cols    = CW'(c);
      rows    = $urandom_range(1, 4);
      en_pool = ($urandom_range(0, 3) != 0);
`ifdef POOL_AVG_EN
      pool_mode = $urandom_range(0, 1) == 1;
`endif
      for (int i = 0; i < rows * (c & ~1); i++) begin
        if ($urandom_range(0, 3) == 0) begin
          drive(1'b0, 1'b0, DW'($urandom));
          checks++;
          if (valid_out !== 1'b0) begin
            errors++;
            $display("FAIL rand_bubble f%0d: got v=%b want 0", f, valid_out);
          end
        end
        if (f % 2 == 0) drive(1'b1, i == 0, DW'($urandom_range(0, 3)));
        else            drive(1'b1, i == 0, DW'($urandom));
        checks++;
        if (valid_out !== exp_v || (exp_v && (data_out !== exp_d || eol_out !== exp_eol))) begin
          errors++;
          $display("FAIL rand f%0d px%0d: got v=%b d=%0d eol=%b want v=%b d=%0d eol=%b", f, i,
                   valid_out, data_out, eol_out, exp_v, exp_d, exp_eol);
        end
      end
    end
    pool_mode = 1'b0;
    en_pool   = 1'b1;
  endtask

`ifdef POOL_AVG_EN
  task automatic test_avg();
    logic [DW-1:0] px [8] = '{1, 5, 2, 3, 4, 0, 9, 7};
    logic [DW-1:0] want [2] = '{2, 5};
    int k = 0;
    cols      = CW'(4);
    en_pool   = 1'b1;
    pool_mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, i == 0, px[i]);
      if (exp_v) begin
        checks++;
        if (valid_out !== 1'b1 || data_out !== want[k] || eol_out !== (k == 1)) begin
          errors++;
          $display("FAIL avg out%0d: got v=%b d=%0d eol=%b want 1 %0d %b", k, valid_out,
                   data_out, eol_out, want[k], k == 1);
        end
        k++;
      end
    end
    pool_mode = 1'b0;
  endtask
`endif

  initial begin
    en_pool   = 1'b1;
    pool_mode = 1'b0;
    cols      = CW'(4);
    sof_in    = 1'b0;
    data_in   = '0;
    valid_in  = 1'b0;
    model_reset();
    test_reset();
    test_basic(0, "basic");
    test_basic(3, "bubbles");
    test_bypass();
    test_basic(0, "after_bypass");
    test_mid_sof();
    test_async_reset();
`ifdef POOL_AVG_EN
    test_avg();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
